// File: rtl/ysyx_22041461_mul_iter.sv
// ysyx_22041461_mul_iter
//   Iterative shift-add multiplier for MUL, MULH, MULHSU, MULHU and MULW. One multiplier
//   bit is retired per BUSY cycle. Operands are reduced to magnitudes at accept and the
//   sign is restored by negating the 128-bit product in DONE.
//
//   Ports
//     clk_i           clock, rising edge
//     rst_ni          asynchronous active-low reset
//     mul_valid_i     request valid; accepted when mul_valid_i && mul_ready_o at an edge
//     flush_i         abort the current operation; blocks accept while idle
//     mulw_i          32-bit MULW operation
//     mul_signed_i    2'b11 signed x signed, 2'b10 signed x unsigned, else unsigned
//     multiplicand_i  rs1 value
//     multiplier_i    rs2 value
//     mul_ready_o     high only while idle
//     out_valid_o     one-cycle pulse, results valid during it
//     result_hi_o     product bits [127:64] (zero for MULW)
//     result_lo_o     product bits [63:0] (sign-extended low word for MULW)
//
//   Optional feature: define YSYX_22041461_MUL_EARLY_EXIT_EN to leave BUSY as soon as the
//   remaining multiplier bits are all zero. Results are unchanged; only latency shrinks.
//
//   Timing: the accept edge loads the operands, DONE is entered after the last BUSY cycle
//   and the registered results plus out_valid_o appear on the edge that leaves DONE
//   (65 edges after accept for 64-bit ops, 33 for MULW).

module ysyx_22041461_mul_iter #(
   parameter int unsigned XLEN = 64
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            mul_valid_i,
   input  logic            flush_i,
   input  logic            mulw_i,
   input  logic [1:0]      mul_signed_i,
   input  logic [XLEN-1:0] multiplicand_i,
   input  logic [XLEN-1:0] multiplier_i,
   output logic            mul_ready_o,
   output logic            out_valid_o,
   output logic [XLEN-1:0] result_hi_o,
   output logic [XLEN-1:0] result_lo_o
);

   localparam int unsigned PW   = 2 * XLEN;
   localparam int unsigned CntW = $clog2(XLEN + 1);
   localparam int unsigned HW   = XLEN / 2;

   typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

   state_e            state_q, state_d;
   logic [PW-1:0]     mcand_q, mcand_d;
   logic [XLEN-1:0]   mplier_q, mplier_d;
   logic [PW-1:0]     acc_q, acc_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic              neg_q, neg_d;
   logic              mulw_q, mulw_d;
   logic              out_valid_q, out_valid_d;
   logic [XLEN-1:0]   res_hi_q, res_hi_d;
   logic [XLEN-1:0]   res_lo_q, res_lo_d;

   // Operand magnitudes at accept; negating -2^63 yields 2^63 as an unsigned value.
   logic              a_neg, b_neg;
   logic [XLEN-1:0]   a_mag, b_mag;
   logic [XLEN-1:0]   mplier_shift;
   logic [PW-1:0]     prod;

   always_comb begin
      a_neg = mul_signed_i[1] & multiplicand_i[XLEN-1];
      b_neg = (mul_signed_i == 2'b11) & multiplier_i[XLEN-1];
      if (mulw_i) begin
         a_mag = {{(XLEN-HW){1'b0}}, multiplicand_i[HW-1:0]};
         b_mag = {{(XLEN-HW){1'b0}}, multiplier_i[HW-1:0]};
      end else begin
         a_mag = a_neg ? ('0 - multiplicand_i) : multiplicand_i;
         b_mag = b_neg ? ('0 - multiplier_i) : multiplier_i;
      end
   end

   assign mplier_shift = mplier_q >> 1;
   // Sign restoration only applies to the full-width product; MULW takes the low word as is.
   assign prod         = (neg_q && !mulw_q) ? ('0 - acc_q) : acc_q;

   always_comb begin
      state_d     = state_q;
      mcand_d     = mcand_q;
      mplier_d    = mplier_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      neg_d       = neg_q;
      mulw_d      = mulw_q;
      out_valid_d = 1'b0;
      res_hi_d    = res_hi_q;
      res_lo_d    = res_lo_q;

      unique case (state_q)
         StIdle: begin
            if (mul_valid_i && !flush_i) begin
               state_d  = StBusy;
               mcand_d  = {{XLEN{1'b0}}, a_mag};
               mplier_d = b_mag;
               acc_d    = '0;
               cnt_d    = mulw_i ? CntW'(HW) : CntW'(XLEN);
               neg_d    = (a_neg ^ b_neg) & ~mulw_i;
               mulw_d   = mulw_i;
            end
         end
         StBusy: begin
            if (flush_i) begin
               state_d = StIdle;
            end else begin
               acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
               mcand_d  = mcand_q << 1;
               mplier_d = mplier_shift;
               cnt_d    = cnt_q - 1'b1;
`ifdef YSYX_22041461_MUL_EARLY_EXIT_EN
               if ((cnt_q == CntW'(1)) || (mplier_shift == '0)) begin
                  state_d = StDone;
               end
`else
               if (cnt_q == CntW'(1)) begin
                  state_d = StDone;
               end
`endif
            end
         end
         StDone: begin
            state_d = StIdle;
            if (!flush_i) begin
               out_valid_d = 1'b1;
               if (mulw_q) begin
                  res_lo_d = {{(XLEN-HW){prod[HW-1]}}, prod[HW-1:0]};
                  res_hi_d = '0;
               end else begin
                  res_lo_d = prod[XLEN-1:0];
                  res_hi_d = prod[PW-1:XLEN];
               end
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= StIdle;
         mcand_q     <= '0;
         mplier_q    <= '0;
         acc_q       <= '0;
         cnt_q       <= '0;
         neg_q       <= 1'b0;
         mulw_q      <= 1'b0;
         out_valid_q <= 1'b0;
         res_hi_q    <= '0;
         res_lo_q    <= '0;
      end else begin
         state_q     <= state_d;
         mcand_q     <= mcand_d;
         mplier_q    <= mplier_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         neg_q       <= neg_d;
         mulw_q      <= mulw_d;
         out_valid_q <= out_valid_d;
         res_hi_q    <= res_hi_d;
         res_lo_q    <= res_lo_d;
      end
   end

   assign mul_ready_o = (state_q == StIdle);
   assign out_valid_o = out_valid_q;
   assign result_hi_o = res_hi_q;
   assign result_lo_o = res_lo_q;

endmodule

// File: tb/tb_ysyx_22041461_mul_iter.sv
// Directed bench for ysyx_22041461_mul_iter: hand-computed products, latency, pulse width,
// ready behaviour, flush, idle-flush accept blocking and asynchronous reset mid-operation.

module tb_ysyx_22041461_mul_iter;

   logic        clk;
   logic        rst_n;
   logic        mul_valid;
   logic        flush;
   logic        mulw;
   logic [1:0]  mul_signed;
   logic [63:0] multiplicand;
   logic [63:0] multiplier;
   logic        mul_ready;
   logic        out_valid;
   logic [63:0] result_hi;
   logic [63:0] result_lo;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct packed {
      logic        w;
      logic [1:0]  s;
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] hi;
      logic [63:0] lo;
   } vec_t;

   vec_t vecs [13];

   ysyx_22041461_mul_iter #(.XLEN(64)) u_dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .mul_valid_i    (mul_valid),
      .flush_i        (flush),
      .mulw_i         (mulw),
      .mul_signed_i   (mul_signed),
      .multiplicand_i (multiplicand),
      .multiplier_i   (multiplier),
      .mul_ready_o    (mul_ready),
      .out_valid_o    (out_valid),
      .result_hi_o    (result_hi),
      .result_lo_o    (result_lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Edges from accept to the out_valid pulse.
   function automatic int exp_lat(input logic w, input logic [1:0] s, input logic [63:0] b);
      int lat;
`ifdef YSYX_22041461_MUL_EARLY_EXIT_EN
      logic [63:0] m;
      int hb;
      if (w) m = {32'b0, b[31:0]};
      else if (s == 2'b11 && b[63]) m = 64'd0 - b;
      else m = b;
      hb = 0;
      for (int i = 0; i < 64; i++) if (m[i]) hb = i + 1;
      lat = ((hb == 0) ? 1 : hb) + 1;
`else
      lat = w ? 33 : 65;
`endif
      return lat;
   endfunction

   task automatic run_op(input vec_t v, input string tag);
      int lat;
      int bad_rdy;
      bit seen;
      @(negedge clk);
      mul_valid    = 1'b1;
      mulw         = v.w;
      mul_signed   = v.s;
      multiplicand = v.a;
      multiplier   = v.b;
      @(posedge clk);
      #1;
      // Scramble inputs after accept; the DUT must ignore them.
      mul_valid    = 1'b0;
      mulw         = ~v.w;
      mul_signed   = ~v.s;
      multiplicand = ~v.a;
      multiplier   = ~v.b;
      lat = 0;
      bad_rdy = 0;
      seen = 1'b0;
      for (int i = 1; i <= 200 && !seen; i++) begin
         @(posedge clk);
         #1;
         if (out_valid) begin
            seen = 1'b1;
            lat = i;
         end else if (mul_ready) begin
            bad_rdy++;
         end
      end
      check_eq({tag, "_seen"}, 128'(seen), 128'(1));
      check_eq({tag, "_lat"}, 128'(lat), 128'(exp_lat(v.w, v.s, v.b)));
      check_eq({tag, "_ready_low"}, 128'(bad_rdy), 128'(0));
      check_eq({tag, "_hi"}, 128'(result_hi), 128'(v.hi));
      check_eq({tag, "_lo"}, 128'(result_lo), 128'(v.lo));
      @(posedge clk);
      #1;
      check_eq({tag, "_pulse"}, 128'(out_valid), 128'(0));
      check_eq({tag, "_hold_lo"}, 128'(result_lo), 128'(v.lo));
   endtask

   initial begin
      int stray;
      vecs[0]  = '{1'b0, 2'b00, 64'd3, 64'd5, 64'd0, 64'hF};
      vecs[1]  = '{1'b0, 2'b11, '1, '1, 64'd0, 64'd1};
      vecs[2]  = '{1'b0, 2'b10, '1, '1, '1, 64'd1};
      vecs[3]  = '{1'b0, 2'b11, 64'h8000_0000_0000_0000, 64'd2, '1, 64'd0};
      vecs[4]  = '{1'b1, 2'b00, 64'h0000_0000_4000_0000, 64'd2, 64'd0,
                   64'hFFFF_FFFF_8000_0000};
      vecs[5]  = '{1'b0, 2'b00, '1, 64'd2, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE};
      vecs[6]  = '{1'b0, 2'b01, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1};
      vecs[7]  = '{1'b0, 2'b11, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, '1,
                   64'hFFFF_FFFF_FFFF_FFF1};
      vecs[8]  = '{1'b0, 2'b00, 64'd12345, 64'd0, 64'd0, 64'd0};
      vecs[9]  = '{1'b1, 2'b11, '1, '1, 64'd0, 64'd1};
      vecs[10] = '{1'b0, 2'b11, 64'd7, 64'd1, 64'd0, 64'd7};
      vecs[11] = '{1'b0, 2'b10, 64'd5, 64'hFFFF_FFFF_FFFF_FFFD, 64'd4,
                   64'hFFFF_FFFF_FFFF_FFF1};
      vecs[12] = '{1'b1, 2'b00, 64'h1234_5678_0000_0003, 64'hABCD_EF00_FFFF_FFFF, 64'd0,
                   64'hFFFF_FFFF_FFFF_FFFD};

      rst_n        = 1'b0;
      mul_valid    = 1'b0;
      flush        = 1'b0;
      mulw         = 1'b0;
      mul_signed   = 2'b00;
      multiplicand = '0;
      multiplier   = '0;

      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_ready", 128'(mul_ready), 128'(1));
      check_eq("rst_valid", 128'(out_valid), 128'(0));
      check_eq("rst_hi", 128'(result_hi), 128'(0));
      check_eq("rst_lo", 128'(result_lo), 128'(0));
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 13; i++) run_op(vecs[i], $sformatf("v%0d", i));

      // Flush while idle blocks the accept.
      @(negedge clk);
      mul_valid = 1'b1;
      flush     = 1'b1;
      multiplicand = 64'd9;
      multiplier   = 64'd9;
      @(posedge clk);
      #1;
      mul_valid = 1'b0;
      flush     = 1'b0;
      check_eq("idle_flush_ready", 128'(mul_ready), 128'(1));

      // Flush in BUSY cycle 10.
      @(negedge clk);
      mul_valid    = 1'b1;
      mulw         = 1'b0;
      mul_signed   = 2'b00;
      multiplicand = 64'd3;
      multiplier   = '1;
      @(posedge clk);
      #1;
      mul_valid = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      check_eq("flush_ready", 128'(mul_ready), 128'(1));
      check_eq("flush_valid", 128'(out_valid), 128'(0));
      check_eq("flush_hold_lo", 128'(result_lo), 128'(vecs[12].lo));
      run_op('{1'b0, 2'b00, 64'd7, 64'd6, 64'd0, 64'd42}, "after_flush");

      // Asynchronous reset in BUSY cycle 20.
      @(negedge clk);
      mul_valid    = 1'b1;
      mulw         = 1'b0;
      mul_signed   = 2'b00;
      multiplicand = 64'd3;
      multiplier   = '1;
      @(posedge clk);
      #1;
      mul_valid = 1'b0;
      repeat (19) @(posedge clk);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("arst_valid", 128'(out_valid), 128'(0));
      check_eq("arst_hi", 128'(result_hi), 128'(0));
      check_eq("arst_lo", 128'(result_lo), 128'(0));
      check_eq("arst_ready", 128'(mul_ready), 128'(1));
      @(negedge clk);
      rst_n = 1'b1;
      stray = 0;
      for (int i = 0; i < 80; i++) begin
         @(posedge clk);
         #1;
         if (out_valid) stray++;
      end
      check_eq("arst_no_valid", 128'(stray), 128'(0));
      check_eq("arst_idle_ready", 128'(mul_ready), 128'(1));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ysyx_22041461_mul_iter.md
Name: ysyx_22041461_mul_iter

Overview:
- Iterative multi-cycle multiplier for the RV64M multiply group: MUL, MULH, MULHSU, MULHU and MULW.
- It is the complement of the combinational divide path in the EXU and takes its operands from the same ALU source buses.
- Uses a shift-add datapath that retires one multiplier bit per cycle.
- Handshakes with the EXU via valid/ready; the EXU stalls until out_valid.

Parameters:
- XLEN, 64, operand width; only 64 is supported.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- mul_valid  input  1  request valid; an operation is accepted when mul_valid and mul_ready are both high at a rising edge.
- flush  input  1  abort the current operation (pipeline flush).
- mulw  input  1  32-bit MULW operation.
- mul_signed  input  2  operand signedness: 2'b11 = signed×signed, 2'b10 = signed×unsigned, 2'b00 = unsigned×unsigned; 2'b01 is treated as 2'b00.
- multiplicand  input  64  rs1 value.
- multiplier  input  64  rs2 value.
- mul_ready  output  1  high only in IDLE.
- out_valid  output  1  one-cycle pulse; results are valid during it.
- result_hi  output  64  product bits [127:64].
- result_lo  output  64  product bits [63:0].

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State goes to IDLE.
  - out_valid=0, result_hi=0, result_lo=0.
  - Internal counter and registers are cleared.
  - mul_ready=1 while in reset and after reset.
- States and transitions:
  - IDLE -> BUSY on accept.
  - BUSY -> DONE when the iteration counter expires.
  - DONE -> IDLE unconditionally.
  - flush in BUSY or DONE forces IDLE on the next edge and suppresses out_valid. flush in IDLE has no effect and blocks any accept in that cycle.
- Accept (IDLE):
  - Operands are sign-interpreted per mul_signed.
  - Each operand is converted to a 64-bit magnitude; -2^63 maps to 2^63 unsigned.
  - neg_flag = sign(a) XOR sign(b), counting only the operands that are signed.
  - If mulw: the low 32 bits of both operands are used, zero-extended, and the counter is loaded with 32. Otherwise the counter is loaded with 64.
  - Inputs are sampled only at accept; changes afterwards are ignored.
- BUSY, once per cycle:
  - If mplier[0] is set, add mcand to the 128-bit accumulator.
  - Shift mcand (128-bit) left by 1 and mplier right by 1.
  - Decrement the counter.
  - Exit to DONE after the cycle in which the counter reaches 0.
- DONE:
  - Accumulator is negated (two's complement, 128-bit) if neg_flag is set and mulw=0.
  - result_lo and result_hi are registered from the final product and out_valid=1 for exactly this cycle.
  - MULW: result_lo = sign-extend(product[31:0]); result_hi = 0; signedness is irrelevant.
- Latency:
  - out_valid is high in the cycle beginning 65 edges after the accept edge for 64-bit ops, 33 for MULW.
  - Back-to-back: the next accept is possible at the edge after DONE.
- Holding: result_hi and result_lo hold their value until the next DONE. They are not cleared by flush, only by reset.
- Boundaries:
  - A zero operand still takes full latency.
  - Overflow of MUL (low half) wraps silently.
  - Reset mid-operation takes effect immediately, with no out_valid.
  - flush coincident with the counter expiry edge: flush wins, so there is no DONE.
  - No backpressure on output: the EXU must capture results on out_valid.

Optional Feature:
- Macro: YSYX_22041461_MUL_EARLY_EXIT_EN.
- When defined, BUSY also exits to DONE at the end of any cycle in which the post-shift mplier is zero.
  - Minimum one BUSY cycle, so e.g. a zero multiplier reaches DONE 2 edges after accept.
  - Results are identical; only latency shrinks.
- When undefined, the fixed 65/33-edge latency applies.

Test Plan:
- MULHU, unsigned, 3×5, mulw=0 -> result_lo=0x000000000000000F, result_hi=0; out_valid exactly 65 edges after accept, single-cycle pulse; mul_ready low throughout.
- Signed×signed 0xFFFFFFFFFFFFFFFF × 0xFFFFFFFFFFFFFFFF -> result_lo=0x0000000000000001, result_hi=0x0000000000000000.
- Signed×unsigned (MULHSU) 0xFFFFFFFFFFFFFFFF × 0xFFFFFFFFFFFFFFFF -> result_hi=0xFFFFFFFFFFFFFFFF, result_lo=0x0000000000000001; also 0x8000000000000000 × 2 signed -> hi=0xFFFFFFFFFFFFFFFF, lo=0.
- MULW 0x0000000040000000 × 2 -> result_lo=0xFFFFFFFF80000000, result_hi=0; out_valid 33 edges after accept.
- Flush asserted in BUSY cycle 10 -> no out_valid, mul_ready=1 the next cycle; the immediately following 7×6 unsigned op returns result_lo=42 with normal latency.
- rst_n pulled low in BUSY cycle 20 -> out_valid=0, results=0, mul_ready=1 asynchronously; no out_valid follows; with EARLY_EXIT_EN, a multiplier of 1 gives out_valid 2 edges after accept.
